// File: rtl/pipeline_sequencer.sv
// Valid/ready sequencer for a STAGES-deep adder pipeline: pause, flush, drain.
// Optional saturating perf counters are enabled by PIPE_SEQ_PERF_CNT_EN.
module pipeline_sequencer #(
   parameter int STAGES = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              pause_req,
   input  logic              flush_req,
   input  logic              drain_req,
   output logic [STAGES-1:0] stage_en,
   output logic [STAGES-1:0] stage_flush,
   output logic              busy,
   output logic              drain_done,
   output logic [2:0]        state,
   output logic [CNT_W-1:0]  op_count,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RUN   = 3'd1;
   localparam logic [2:0] PAUSE = 3'd2;
   localparam logic [2:0] FLUSH = 3'd3;
   localparam logic [2:0] DRAIN = 3'd4;

   logic [STAGES-1:0] stage_valid;
   logic [STAGES-1:0] valid_nxt;
   logic [2:0]        state_nxt;
   logic              pause_q;
   logic              flush_q;
   logic              flush_pause;
   logic              drain_ack;
   logic              done_nxt;
   logic              advance;
   logic              accept;
   logic              flowing;
   logic              open_st;

   always_comb begin
      flowing  = (state == IDLE) || (state == RUN) || (state == DRAIN);
      open_st  = (state == IDLE) || (state == RUN);
      // reset gates advance so nothing looks ready while rst is low
      advance  = rst && flowing
               && (!stage_valid[STAGES-1] || out_ready);
      in_ready = advance && open_st && !flush_q
               && !pause_q && !drain_req;
      accept   = in_valid && in_ready;
      out_valid = stage_valid[STAGES-1]
                && (state != PAUSE) && (state != FLUSH);
      stage_en    = {STAGES{advance}};
      stage_flush = (state == FLUSH) ? '1 : '0;
      busy        = |stage_valid;
   end

   always_comb begin
      valid_nxt = stage_valid;
      if (flush_q)
         valid_nxt = '0;
      else if (advance)
         valid_nxt = {stage_valid[STAGES-2:0], accept};
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      if (flush_q) begin
         state_nxt = FLUSH;
      end else begin
         case (state)
            FLUSH: begin
               if (pause_q || flush_pause)
                  state_nxt = PAUSE;
               else
                  state_nxt = IDLE;
            end
            PAUSE: begin
               if (!pause_q)
                  state_nxt = busy ? RUN : IDLE;
            end
            IDLE, RUN: begin
               if (pause_q) begin
                  state_nxt = PAUSE;
               end else if (drain_req && !drain_ack) begin
                  if (valid_nxt == '0) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = DRAIN;
                  end
               end else if (accept) begin
                  state_nxt = RUN;
               end else if (valid_nxt == '0) begin
                  state_nxt = IDLE;
               end
            end
            DRAIN: begin
               if (pause_q) begin
                  state_nxt = PAUSE;
               end else if (valid_nxt == '0) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // drain_ack stops a held drain_req from re-pulsing drain_done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         stage_valid <= '0;
         pause_q     <= 1'b0;
         flush_q     <= 1'b0;
         flush_pause <= 1'b0;
         drain_ack   <= 1'b0;
         drain_done  <= 1'b0;
      end else begin
         state       <= state_nxt;
         stage_valid <= valid_nxt;
         pause_q     <= pause_req;
         flush_q     <= flush_req;
         flush_pause <= flush_q && pause_q;
         drain_done  <= done_nxt;
         if (!drain_req)
            drain_ack <= 1'b0;
         else if (done_nxt)
            drain_ack <= 1'b1;
      end
   end

`ifdef PIPE_SEQ_PERF_CNT_EN
   logic stall;

   always_comb begin
      stall = (state == PAUSE) || (out_valid && !out_ready);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_count    <= '0;
         stall_count <= '0;
      end else begin
         if (out_valid && out_ready && (op_count != '1))
            op_count <= op_count + 1'b1;
         if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end
`else
   assign op_count    = '0;
   assign stall_count = '0;
`endif

endmodule
